// File: rtl/pkfb_pkg.sv
// pkfb_pkg: shared types and sizing helpers for the packet FIFO
package pkfb_pkg;
   localparam int PKFB_DATA_W = 32;
   localparam int PKFB_DEPTH  = 64;
   localparam int PKFB_PTR_W  = $clog2(PKFB_DEPTH) + 1;
   localparam int PKFB_CNT_W  = PKFB_PTR_W;
   typedef struct packed {
      logic                   eof;
      logic [PKFB_DATA_W-1:0] data;
   } pkfb_entry_t;
   typedef enum logic [1:0] {CH_IDLE, CH_PKT, CH_DROP} ch_state_t;
   function automatic int pkfb_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/pkfb_chan_fifo.sv
// pkfb_chan_fifo: one channel of packet storage with commit, drop and overflow tracking
module pkfb_chan_fifo
   import pkfb_pkg::*;
#(
   parameter int DATA_W       = PKFB_DATA_W,
   parameter int DEPTH        = PKFB_DEPTH,
   parameter int DROP_PARTIAL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              err,
   input  logic              sof,
   input  logic              eof,
   input  logic [DATA_W-1:0] data,
   input  logic              ovf_clr,
   input  logic              pop,
   output logic              rd_valid,
   output logic              rd_eof,
   output logic [DATA_W-1:0] rd_data,
   output logic              pkt_avail,
   output logic              ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = pkfb_ptr_w(DEPTH);
   typedef struct packed {
      logic              eof;
      logic [DATA_W-1:0] data;
   } entry_t;
   entry_t            mem [DEPTH];
   entry_t            head;
   ch_state_t         state, state_nxt;
   logic [PW-1:0]     wr_ptr, rd_ptr, commit_ptr, pkt_cnt;
   logic [PW-1:0]     base, wr_nxt, commit_nxt;
   logic              full, skip, accept, reject, commit, eof_pop;
   // A SOF push restarts from the last committed word, so fullness is judged on the rewound pointer
   assign base    = (DROP_PARTIAL != 0 && sof) ? commit_ptr : wr_ptr;
   assign full    = (base[AW] != rd_ptr[AW]) && (base[AW-1:0] == rd_ptr[AW-1:0]);
   assign skip    = (state == CH_DROP) && !sof;
   assign accept  = push && !skip && !full;
   assign reject  = push && !skip && full;
   assign commit  = accept && eof;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign rd_valid  = rd_ptr != commit_ptr;
   assign rd_data   = rd_valid ? head.data : '0;
   assign rd_eof    = rd_valid && head.eof;
   assign eof_pop   = pop && rd_valid && head.eof;
   assign pkt_avail = pkt_cnt != '0;
   assign wr_nxt     = accept ? base + PW'(1) : (reject && DROP_PARTIAL != 0) ? commit_ptr : wr_ptr;
   assign commit_nxt = (DROP_PARTIAL == 0) ? wr_nxt : commit ? base + PW'(1) : commit_ptr;
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = eof ? CH_IDLE : CH_PKT;
      else if (reject && DROP_PARTIAL != 0) state_nxt = CH_DROP;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CH_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         commit_ptr <= '0;
         pkt_cnt    <= '0;
         ovf        <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_nxt;
         commit_ptr <= commit_nxt;
         rd_ptr     <= rd_ptr + PW'(pop && rd_valid);
         pkt_cnt    <= pkt_cnt + PW'(commit) - PW'(eof_pop);
         ovf        <= reject || err || (ovf && !ovf_clr);
      end
   end
   always_ff @(posedge clk) begin
      if (accept) mem[base[AW-1:0]] <= '{eof: eof, data: data};
   end
endmodule

// File: rtl/pkfb_packet_fifo.sv
// pkfb_packet_fifo: multi-channel packet FIFO with push error decode and drain-port mux
module pkfb_packet_fifo
   import pkfb_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DATA_W       = PKFB_DATA_W,
   parameter int DEPTH        = PKFB_DEPTH,
   parameter int DROP_PARTIAL = 1
) (
   input  logic                                     Sys_PKfb_Clk,
   input  logic                                     Sys_PKfb_Rst,
   input  logic [DATA_W-1:0]                        FB_PKfbData,
   input  logic [NUM_CH-1:0]                        FB_PKfbPush,
   input  logic                                     FB_PKfbSOF,
   input  logic                                     FB_PKfbEOF,
   output logic [NUM_CH-1:0]                        FB_PKfbOverflow,
   input  logic [NUM_CH-1:0]                        Ovf_Clr,
   input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] Rd_Ch,
   input  logic                                     Rd_Pop,
   output logic [DATA_W-1:0]                        Rd_Data,
   output logic                                     Rd_Valid,
   output logic                                     Rd_EOF,
   output logic [NUM_CH-1:0]                        Pkt_Avail
);
   localparam int RW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   logic [DATA_W-1:0] ch_data [NUM_CH];
   logic [NUM_CH-1:0] ch_valid, ch_eof;
   logic              multi, sel_ok;
   // More than one push strobe is a protocol error: nothing is written anywhere
   assign multi  = (FB_PKfbPush & (FB_PKfbPush - NUM_CH'(1))) != '0;
   assign sel_ok = int'(Rd_Ch) < NUM_CH;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pkfb_chan_fifo #(
         .DATA_W(DATA_W),
         .DEPTH(DEPTH),
         .DROP_PARTIAL(DROP_PARTIAL)
      ) u_chan (
         .clk(Sys_PKfb_Clk),
         .rst(Sys_PKfb_Rst),
         .push(FB_PKfbPush[i] && !multi),
         .err(FB_PKfbPush[i] && multi),
         .sof(FB_PKfbSOF),
         .eof(FB_PKfbEOF),
         .data(FB_PKfbData),
         .ovf_clr(Ovf_Clr[i]),
         .pop(Rd_Pop && Rd_Ch == RW'(i)),
         .rd_valid(ch_valid[i]),
         .rd_eof(ch_eof[i]),
         .rd_data(ch_data[i]),
         .pkt_avail(Pkt_Avail[i]),
         .ovf(FB_PKfbOverflow[i])
      );
   end
   assign Rd_Valid = sel_ok && ch_valid[Rd_Ch];
   assign Rd_EOF   = sel_ok && ch_eof[Rd_Ch];
   assign Rd_Data  = sel_ok ? ch_data[Rd_Ch] : '0;
endmodule

// File: tb/tb_pkfb_packet_fifo.sv
// tb_pkfb_packet_fifo: directed and random stimulus against a queue-based packet model
module tb_pkfb_packet_fifo;
   localparam int NCH = 4;
   localparam int DEP = 64;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] data = '0;
   logic [3:0]  push = '0, clr = '0;
   logic        sof = 1'b0, eof = 1'b0, pop = 1'b0;
   logic [1:0]  rd_ch = '0;
   logic [3:0]  ovf, avail;
   logic [31:0] rdata;
   logic        rvalid, reof;
   int          n_tests = 0, n_fail = 0;
   logic [32:0] com_q [NCH][$];
   logic [32:0] pend_q [NCH][$];
   bit          drop [NCH];
   logic [3:0]  m_ovf = '0;

   pkfb_packet_fifo dut (
      .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst(rst), .FB_PKfbData(data), .FB_PKfbPush(push),
      .FB_PKfbSOF(sof), .FB_PKfbEOF(eof), .FB_PKfbOverflow(ovf), .Ovf_Clr(clr),
      .Rd_Ch(rd_ch), .Rd_Pop(pop), .Rd_Data(rdata), .Rd_Valid(rvalid), .Rd_EOF(reof),
      .Pkt_Avail(avail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         com_q[c].delete();
         pend_q[c].delete();
         drop[c] = 0;
      end
      m_ovf = '0;
   endtask

   function automatic logic [3:0] m_avail();
      logic [3:0] a = '0;
      for (int c = 0; c < NCH; c++)
         foreach (com_q[c][k]) if (com_q[c][k][32]) a[c] = 1'b1;
      return a;
   endfunction

   // Applies one clock of the current inputs to the model; occupancy uses pre-edge committed sizes
   task automatic model_step();
      int occ [NCH];
      int c;
      for (int k = 0; k < NCH; k++) occ[k] = com_q[k].size();
      if (pop && com_q[rd_ch].size() > 0) void'(com_q[rd_ch].pop_front());
      m_ovf = m_ovf & ~clr;
      if ($countones(push) > 1) m_ovf = m_ovf | push;
      else if (push != '0) begin
         c = 0;
         for (int k = 0; k < NCH; k++) if (push[k]) c = k;
         if (!(drop[c] && !sof)) begin
            if (sof) pend_q[c].delete();
            if (occ[c] + pend_q[c].size() >= DEP) begin
               m_ovf[c] = 1'b1;
               pend_q[c].delete();
               drop[c] = 1;
            end else begin
               pend_q[c].push_back({eof, data});
               drop[c] = 0;
               if (eof) begin
                  foreach (pend_q[c][k]) com_q[c].push_back(pend_q[c][k]);
                  pend_q[c].delete();
               end
            end
         end
      end
   endtask

   task automatic compare(input string tag);
      logic [32:0] f;
      bit v = com_q[rd_ch].size() > 0;
      check({tag, ".valid"}, rvalid, v);
      if (v) begin
         f = com_q[rd_ch][0];
         check({tag, ".data"}, rdata, f[31:0]);
         check({tag, ".eof"}, reof, f[32]);
      end
      check({tag, ".avail"}, avail, m_avail());
      check({tag, ".ovf"}, ovf, m_ovf);
   endtask

   task automatic cyc(input logic [3:0] p, input logic s, input logic e, input logic [31:0] d,
                      input logic [3:0] c, input logic [1:0] ch, input logic pp, input string tag);
      push = p; sof = s; eof = e; data = d; clr = c; rd_ch = ch; pop = pp;
      model_step();
      @(posedge clk);
      #1;
      push = '0; sof = 1'b0; eof = 1'b0; clr = '0; pop = 1'b0;
      compare(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare("reset");
      check("reset.data", rdata, 0);
      rst = 1'b0;
      // 1: three-word packet on ch0
      cyc(4'b0001, 1, 0, 32'h1000, 0, 0, 0, "t1.w0");
      cyc(4'b0001, 0, 0, 32'h1001, 0, 0, 0, "t1.w1");
      cyc(4'b0001, 0, 1, 32'h1002, 0, 0, 0, "t1.w2");
      check("t1.avail", avail, 4'b0001);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, "t1.pop");
      // 2: overflow on ch1 without EOF, then a clean 4-word packet
      for (int i = 0; i < 70; i++) cyc(4'b0010, i == 0, 0, $urandom, 0, 1, 0, "t2.fill");
      check("t2.ovf1", ovf[1], 1);
      for (int i = 0; i < 4; i++) cyc(4'b0010, i == 0, i == 3, 32'h2000 + i, 0, 1, 0, "t2.pkt");
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 1, "t2.pop");
      cyc(0, 0, 0, 0, 4'b0010, 1, 0, "t2.clr");
      // 3: 5-word packet plus single-word packet on ch2
      for (int i = 0; i < 5; i++) cyc(4'b0100, i == 0, i == 4, 32'h3000 + i, 0, 2, 0, "t3.p0");
      cyc(4'b0100, 1, 1, 32'h3100, 0, 2, 0, "t3.p1");
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 2, 1, "t3.pop");
      check("t3.avail2", avail[2], 0);
      // 4: multi-push protocol error, then clear racing a fresh overflow
      cyc(4'b0011, 1, 1, 32'hA5A5A5A5, 0, 0, 0, "t4.multi");
      check("t4.ovf", ovf, 4'b0011);
      cyc(4'b0101, 1, 1, 32'hA5A5A5A5, 4'b0001, 0, 0, "t4.race");
      check("t4.ovf0", ovf[0], 1);
      cyc(0, 0, 0, 0, 4'b1111, 0, 0, "t4.clr");
      // 5: commit and EOF pop in the same cycle on ch3, then wrap the pointers
      cyc(4'b1000, 1, 1, 32'h5000, 0, 3, 0, "t5.p0");
      cyc(4'b1000, 1, 1, 32'h5001, 0, 3, 1, "t5.both");
      check("t5.avail3", avail[3], 1);
      for (int i = 0; i < 150; i++)
         cyc(4'b1000, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom, 0, 3,
             $urandom_range(0, 1), "t5.wrap");
      // random traffic on all channels
      for (int i = 0; i < 2000; i++) begin
         int r = $urandom_range(0, 9);
         logic [3:0] p = r < 6 ? 4'b0001 << $urandom_range(0, 3) : r < 7 ? 4'($urandom) : 4'b0000;
         cyc(p, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
             $urandom_range(0, 15) == 0 ? 4'($urandom) : 4'b0000, 2'($urandom), $urandom_range(0, 1),
             "rnd");
      end
      // 6: reset with one committed packet and a partial one in flight
      cyc(0, 0, 0, 0, 4'b1111, 0, 0, "t6.clr");
      cyc(4'b0001, 1, 1, 32'h6000, 0, 0, 0, "t6.pkt");
      cyc(4'b0001, 1, 0, 32'h6001, 0, 0, 0, "t6.part");
      rst = 1'b1;
      #1;
      check("t6.valid", rvalid, 0);
      check("t6.eof", reof, 0);
      check("t6.data", rdata, 0);
      check("t6.avail", avail, 0);
      check("t6.ovf", ovf, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < NCH; c++) cyc(0, 0, 0, 0, 0, 2'(c), 0, "t6.after");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
